mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Sequencing controller for the accumulator/MD shift-add multiply datapath.
- Accepts a start/done handshake from the main instruction control unit.
- Steps the datapath through load, clear, WIDTH add/shift iterations and completion, driving the ENDES/LMD/LAC/OP2/SD0/LRESET/LINT strobes.
- Replaces the hand-unrolled per-bit T-states of the MUL instruction with one counted loop.

Parameters:
- WIDTH, 8, operand width = number of multiply iterations.
- CNT_W, 3, bit-index counter width; must equal clog2(WIDTH).

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE with no done.
- md_bit  input  1  datapath MD[bit_sel], combinational.
- zero_a  input  1  accumulator operand == 0.
- zero_b  input  1  MD operand == 0.
- bit_sel  output  CNT_W  current multiplier bit index (= counter).
- endes  output  1  enable internal data bus source.
- lmd  output  1  load MD from bus.
- lac  output  1  load accumulator/product.
- op2  output  1  ALU add operation select.
- sd0  output  1  shift-right-through-product select.
- lreset  output  1  clear product/flag registers.
- lint  output  1  load internal temp register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- zero_flag  output  1  result forced zero (shortcut taken); valid with done.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, zero_flag=0; every strobe, busy and done are 0. This applies mid-operation too: no partial strobe is issued after reset releases.
- States: IDLE, LOAD, CLEAR, STEP, SHIFT, DONE.
  - State register and counter are clocked.
  - Strobes are decoded combinationally from state; in STEP they also depend on md_bit.
- IDLE:
  - Strobes 0, busy=0.
  - start=1 -> LOAD. start is ignored in every other state.
- LOAD:
  - endes=1, lmd=1, busy=1.
  - -> CLEAR.
- CLEAR:
  - lreset=1, lint=1, busy=1; counter <= 0.
  - If zero_a|zero_b: zero_flag <= 1, -> DONE.
  - Else zero_flag <= 0, -> STEP.
- STEP, md_bit=1:
  - endes=1, op2=1, lac=1 (add); counter unchanged.
  - -> SHIFT.
- STEP, md_bit=0:
  - endes=1, sd0=1, lac=1 (shift).
  - If counter==WIDTH-1 -> DONE; else counter++, stay in STEP.
- SHIFT:
  - endes=1, sd0=1, lac=1.
  - If counter==WIDTH-1 -> DONE; else counter++, -> STEP.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - -> IDLE. start may be accepted on the following cycle, not in DONE itself.
- Invariants:
  - Exactly one of {op2, sd0} is asserted when lac=1 in STEP/SHIFT.
  - lmd is never asserted together with lac.
- Counter:
  - Unsigned, never wraps; it saturates at WIDTH-1 because exit precedes increment.
  - bit_sel = counter in all states (0 in IDLE).
- Latency, with start sampled at edge 0:
  - Nonzero operands: done high in cycle 3+WIDTH+popcount(multiplier).
  - Zero shortcut: done high in cycle 3.
- abort=1 in any non-IDLE state: next state is IDLE, counter cleared, no done pulse. abort has priority over all other transitions.
- Simultaneous zero_a and zero_b: same as a single zero, one shortcut.

Decomposition:
- Shared package mul_ctrl_pkg:
  - State encoding enum (IDLE..DONE).
  - Strobe-vector bit indices (ENDES, LMD, LAC, OP2, SD0, LRESET, LINT), so the main instruction control unit and this block agree.
- No sub-module. The strobe decoder is a single combinational function of (state, md_bit).

Test Plan:
- Reset mid-STEP (assert reset_n=0 at cycle 5) -> all outputs 0 immediately; after release, state IDLE with no spurious strobes.
- WIDTH=8, multiplier md bits 0x05, nonzero operands, start pulse:
  - LOAD in cycle 1, CLEAR in cycle 2.
  - Add at bit_sel 0 and 2, 8 shifts total.
  - done in cycle 13, zero_flag=0.
- Multiplier 0xFF -> 8 adds interleaved with 8 shifts; done in cycle 19; op2 and sd0 never high together.
- zero_b=1 during CLEAR -> no STEP entered; done in cycle 3 with zero_flag=1.
- start held high continuously -> operations back-to-back, with one IDLE cycle between DONE and the next LOAD; start during busy has no effect.
- abort=1 at cycle 6 -> IDLE in cycle 7, done stays 0, bit_sel=0; a following start behaves normally.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the shift-add multiply sequencer: state encoding,
// strobe-vector bit positions and the state/md_bit -> strobe decoder.
package mul_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_STEP  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int unsigned NUM_STROBES = 7;

  localparam int unsigned STB_ENDES  = 0;
  localparam int unsigned STB_LMD    = 1;
  localparam int unsigned STB_LAC    = 2;
  localparam int unsigned STB_OP2    = 3;
  localparam int unsigned STB_SD0    = 4;
  localparam int unsigned STB_LRESET = 5;
  localparam int unsigned STB_LINT   = 6;

  typedef logic [NUM_STROBES-1:0] strobe_t;

  // In STEP the multiplier bit picks add (op2) or shift (sd0); never both.
  function automatic strobe_t decode_strobes(input state_e st, input logic md_bit);
    strobe_t s;
    s = '0;
    case (st)
      ST_LOAD: begin
        s[STB_ENDES] = 1'b1;
        s[STB_LMD]   = 1'b1;
      end
      ST_CLEAR: begin
        s[STB_LRESET] = 1'b1;
        s[STB_LINT]   = 1'b1;
      end
      ST_STEP: begin
        s[STB_ENDES] = 1'b1;
        s[STB_LAC]   = 1'b1;
        s[STB_OP2]   = md_bit;
        s[STB_SD0]   = ~md_bit;
      end
      ST_SHIFT: begin
        s[STB_ENDES] = 1'b1;
        s[STB_LAC]   = 1'b1;
        s[STB_SD0]   = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic state_is_busy(input state_e st);
    return (st == ST_LOAD) || (st == ST_CLEAR) || (st == ST_STEP) || (st == ST_SHIFT);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Counted-loop sequencer for the accumulator/MD shift-add multiplier:
// load, clear, WIDTH add/shift iterations, one-cycle done pulse.
module mul_seq_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             md_bit,
  input  logic             zero_a,
  input  logic             zero_b,
  output logic [CNT_W-1:0] bit_sel,
  output logic             endes,
  output logic             lmd,
  output logic             lac,
  output logic             op2,
  output logic             sd0,
  output logic             lreset,
  output logic             lint,
  output logic             busy,
  output logic             done,
  output logic             zero_flag
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_flag_q, zero_flag_d;
  logic             last_bit;
  strobe_t          strobes;

  assign last_bit = (cnt_q == LAST_BIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  // Exit test precedes increment, so the counter saturates at WIDTH-1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    zero_flag_d = zero_flag_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_CLEAR;
      ST_CLEAR: begin
        cnt_d = '0;
        if (zero_a || zero_b) begin
          zero_flag_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          zero_flag_d = 1'b0;
          state_d     = ST_STEP;
        end
      end
      ST_STEP: begin
        if (md_bit) begin
          state_d = ST_SHIFT;
        end else if (last_bit) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_STEP;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign strobes = decode_strobes(state_q, md_bit);

  assign endes     = strobes[STB_ENDES];
  assign lmd       = strobes[STB_LMD];
  assign lac       = strobes[STB_LAC];
  assign op2       = strobes[STB_OP2];
  assign sd0       = strobes[STB_SD0];
  assign lreset    = strobes[STB_LRESET];
  assign lint      = strobes[STB_LINT];
  assign busy      = state_is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign bit_sel   = cnt_q;
  assign zero_flag = zero_flag_q;

endmodule
